// File: rtl/amp_mod_multichannel.sv
// Multichannel amplitude stage: scales each voice by its envelope and a slewed master gain
// through one time-shared multiplier, then emits all channel results plus their average.
module amp_mod_multichannel #(
  parameter int CHANNELS  = 4,
  parameter int DATA_W    = 8,
  parameter int SLEW_STEP = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sample_valid,
  output logic                         sample_ready,
  input  logic [CHANNELS*DATA_W-1:0]   waveform_in,
  input  logic [CHANNELS*DATA_W-1:0]   envelope_in,
  input  logic [DATA_W-1:0]            master_amplitude,
  output logic [CHANNELS*DATA_W-1:0]   amplitude_out,
  output logic [DATA_W-1:0]            mix_out,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            gain_out
);

  localparam int LOG2C = $clog2(CHANNELS);
  localparam int IDX_W = (LOG2C == 0) ? 1 : LOG2C;
  localparam int SUM_W = DATA_W + LOG2C;
  localparam logic [DATA_W:0]  STEP = (DATA_W+1)'(SLEW_STEP);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(CHANNELS - 1);

  typedef enum logic [1:0] {IDLE, MUL_ENV, MUL_GAIN, MIX} state_t;

  state_t                       r_state;
  logic [IDX_W-1:0]             r_idx;
  logic [CHANNELS*DATA_W-1:0]   r_wave;
  logic [CHANNELS*DATA_W-1:0]   r_env;
  logic [CHANNELS*DATA_W-1:0]   r_res;
  logic [CHANNELS*DATA_W-1:0]   r_amp;
  logic [DATA_W-1:0]            r_stage1;
  logic [DATA_W-1:0]            r_gain;
  logic [DATA_W-1:0]            r_mix;
  logic                         r_valid;

  logic [DATA_W-1:0]            w_op_a;
  logic [DATA_W-1:0]            w_op_b;
  logic [2*DATA_W-1:0]          w_prod;
  logic [DATA_W-1:0]            w_prod_hi;
  logic [SUM_W-1:0]             w_sum;
  logic [DATA_W-1:0]            w_mix;
  int                           w_base;

  // Move the gain toward the target by at most STEP per accepted frame.
  function automatic logic [DATA_W-1:0] slew_gain(input logic [DATA_W-1:0] cur,
                                                  input logic [DATA_W-1:0] tgt);
    logic [DATA_W:0] diff;
    if (SLEW_STEP == 0) return tgt;
    if (tgt >= cur) begin
      diff = {1'b0, tgt} - {1'b0, cur};
      return (diff <= STEP) ? tgt : cur + STEP[DATA_W-1:0];
    end
    diff = {1'b0, cur} - {1'b0, tgt};
    return (diff <= STEP) ? tgt : cur - STEP[DATA_W-1:0];
  endfunction

  assign w_base = int'(r_idx) * DATA_W;

  always_comb begin
    w_op_a = r_wave[w_base +: DATA_W];
    w_op_b = r_env[w_base +: DATA_W];
    if (r_state == MUL_GAIN) begin
      w_op_a = r_stage1;
      w_op_b = r_gain;
    end
  end

  assign w_prod    = {{DATA_W{1'b0}}, w_op_a} * {{DATA_W{1'b0}}, w_op_b};
  assign w_prod_hi = DATA_W'(w_prod >> DATA_W);

  always_comb begin
    w_sum = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_sum = w_sum + SUM_W'(r_res[c*DATA_W +: DATA_W]);
    end
  end

  assign w_mix = DATA_W'(w_sum >> LOG2C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_wave   <= '0;
      r_env    <= '0;
      r_res    <= '0;
      r_amp    <= '0;
      r_stage1 <= '0;
      r_gain   <= '0;
      r_mix    <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (sample_valid) begin
            r_wave  <= waveform_in;
            r_env   <= envelope_in;
            r_gain  <= slew_gain(r_gain, master_amplitude);
            r_idx   <= '0;
            r_state <= MUL_ENV;
          end
        end
        MUL_ENV: begin
          r_stage1 <= w_prod_hi;
          r_state  <= MUL_GAIN;
        end
        MUL_GAIN: begin
          r_res[w_base +: DATA_W] <= w_prod_hi;
          if (r_idx == LAST) begin
            r_state <= MIX;
          end else begin
            r_idx   <= r_idx + IDX_W'(1);
            r_state <= MUL_ENV;
          end
        end
        MIX: begin
          r_amp   <= r_res;
          r_mix   <= w_mix;
          r_valid <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sample_ready  = (r_state == IDLE);
  assign amplitude_out = r_amp;
  assign mix_out       = r_mix;
  assign out_valid     = r_valid;
  assign gain_out      = r_gain;

endmodule

// File: tb/tb_amp_mod_multichannel.sv
// Scoreboard bench for amp_mod_multichannel: one instance without slew limiting,
// one with SLEW_STEP=16, sharing clock, reset and data inputs.
module tb_amp_mod_multichannel;

  logic        clk;
  logic        rst_n;
  logic        valid_a, valid_b;
  logic [31:0] wave, env;
  logic [7:0]  master;

  logic        ready_a, ov_a, ready_b, ov_b;
  logic [31:0] amp_a, amp_b;
  logic [7:0]  mix_a, gain_a, mix_b, gain_b;

  typedef struct packed {
    logic [31:0] amp;
    logic [7:0]  mix;
    logic [7:0]  gain;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  amp_mod_multichannel #(.CHANNELS(4), .DATA_W(8), .SLEW_STEP(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .sample_valid(valid_a), .sample_ready(ready_a),
    .waveform_in(wave), .envelope_in(env), .master_amplitude(master),
    .amplitude_out(amp_a), .mix_out(mix_a), .out_valid(ov_a), .gain_out(gain_a));

  amp_mod_multichannel #(.CHANNELS(4), .DATA_W(8), .SLEW_STEP(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .sample_valid(valid_b), .sample_ready(ready_b),
    .waveform_in(wave), .envelope_in(env), .master_amplitude(master),
    .amplitude_out(amp_b), .mix_out(mix_b), .out_valid(ov_b), .gain_out(gain_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t ex(input logic [31:0] a, input logic [7:0] m, input logic [7:0] g);
    exp_t r;
    r.amp = a; r.mix = m; r.gain = g;
    return r;
  endfunction

  // Reference for one channel: (w*e >> 8) * g >> 8, truncating.
  function automatic logic [7:0] ch_model(input logic [7:0] w, input logic [7:0] e,
                                          input logic [7:0] g);
    logic [15:0] p;
    logic [7:0]  s;
    p = w * e;
    s = p[15:8];
    p = s * g;
    return p[15:8];
  endfunction

  function automatic exp_t mk_exp(input logic [31:0] w, input logic [31:0] e,
                                  input logic [7:0] g);
    exp_t r;
    int   sum;
    sum = 0;
    for (int c = 0; c < 4; c++) begin
      r.amp[c*8 +: 8] = ch_model(w[c*8 +: 8], e[c*8 +: 8], g);
      sum += int'(r.amp[c*8 +: 8]);
    end
    r.mix  = 8'(sum >> 2);
    r.gain = g;
    return r;
  endfunction

  task automatic send(input bit to_b, input logic [31:0] w, input logic [31:0] e,
                      input logic [7:0] m, input bit push, input exp_t x);
    int t;
    t = 0;
    @(negedge clk);
    while (!(to_b ? ready_b : ready_a) && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (t >= 60) begin
      n_cmp++; n_fail++;
      $display("FAIL ready_timeout: got busy expected ready within 60 cycles");
    end
    wave = w; env = e; master = m;
    if (to_b) valid_b = 1'b1; else valid_a = 1'b1;
    if (push) begin
      if (to_b) qb.push_back(x); else qa.push_back(x);
    end
    @(posedge clk);
    #1;
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever either instance pulses out_valid.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ov_a) begin
        if (qa.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL a_unexpected_valid: got out_valid=1 expected no output at %0t", $time);
        end else begin
          e = qa.pop_front();
          chk("a_amp", amp_a, e.amp);
          chk("a_mix", mix_a, e.mix);
          chk("a_gain", gain_a, e.gain);
        end
      end
      if (ov_b) begin
        if (qb.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL b_unexpected_valid: got out_valid=1 expected no output at %0t", $time);
        end else begin
          e = qb.pop_front();
          chk("b_amp", amp_b, e.amp);
          chk("b_mix", mix_b, e.mix);
          chk("b_gain", gain_b, e.gain);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat, t;
    bit   found, seen;
    logic [7:0] g;
    rst_n = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
    wave = '0; env = '0; master = '0;

    #1;
    chk("rst_ready_a", ready_a, 1);
    chk("rst_amp_a", amp_a, 0);
    chk("rst_mix_a", mix_a, 0);
    chk("rst_valid_a", ov_a, 0);
    chk("rst_gain_a", gain_a, 0);
    chk("rst_ready_b", ready_b, 1);
    chk("rst_gain_b", gain_b, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Slewed gain ramps 0x10 per frame toward 0xFF, then down toward 0x00.
    for (int k = 1; k <= 16; k++) begin
      g = (k < 16) ? 8'(k * 16) : 8'hFF;
      send(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'hFF, 1, mk_exp(32'hFFFFFFFF, 32'hFFFFFFFF, g));
    end
    send(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'h00, 1, mk_exp(32'hFFFFFFFF, 32'hFFFFFFFF, 8'hEF));
    repeat (3) @(negedge clk);
    chk("b_gain_hold_midframe", gain_b, 8'hEF);

    // Full scale, with latency and pulse width.
    send(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'hFF, 1, ex(32'hFDFDFDFD, 8'hFD, 8'hFF));
    lat = 0; found = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ov_a) begin
        lat = k - 1; found = 1'b1;
        chk("a_ready_with_valid", ready_a, 1);
        break;
      end
    end
    chk("a_valid_seen", found, 1);
    chk("a_latency", lat, 9);
    @(negedge clk);
    chk("a_pulse_width", ov_a, 0);

    send(0, 32'h001080FF, 32'hFFFFFFFF, 8'h80, 1, ex(32'h00073F7F, 8'h31, 8'h80));
    send(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'h00, 1, ex(32'h00000000, 8'h00, 8'h00));
    send(0, 32'hFFFFFFFF, 32'hFF00FFFF, 8'hFF, 1, ex(32'hFD00FDFD, 8'hBD, 8'hFF));

    // Abort a frame in MUL_GAIN of channel 1.
    send(0, 32'h001080FF, 32'hFFFFFFFF, 8'h80, 0, ex(32'h0, 8'h0, 8'h0));
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_amp", amp_a, 0);
    chk("abort_mix", mix_a, 0);
    chk("abort_gain", gain_a, 0);
    chk("abort_valid", ov_a, 0);
    chk("abort_ready", ready_a, 1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (ov_a) seen = 1'b1;
    end
    chk("abort_no_valid", seen, 0);
    send(0, 32'h001080FF, 32'hFFFFFFFF, 8'h80, 1, ex(32'h00073F7F, 8'h31, 8'h80));

    // Valid held high with data and master changing every cycle.
    t = 0;
    @(negedge clk);
    while (!ready_a && t < 60) begin
      @(negedge clk);
      t++;
    end
    valid_a = 1'b1;
    for (int c = 0; c < 40; c++) begin
      wave   = {8'(c * 7), 8'(c * 13 + 5), 8'(255 - c), 8'(c * 3)};
      env    = {8'hFF, 8'(c * 11), 8'h80, 8'(8'hC0 + c)};
      master = 8'(c * 29 + 3);
      chk("a_ready_spacing", ready_a, (c % 10) == 0);
      if ((c % 10) == 0) qa.push_back(mk_exp(wave, env, master));
      @(negedge clk);
    end
    valid_a = 1'b0;

    t = 0;
    while ((qa.size() != 0 || qb.size() != 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("queues_drained", qa.size() + qb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
